uart_wb_sched: RTL

Wishbone-master scheduler that owns the bus port of the `uart_wb` peripheral and sequences all access to it. It programs the baud divider after reset and on request, polls the UART status word, and drains received bytes to a strobe output. It also shares the TX path between two byte-stream requesters with round-robin arbitration. It sits between the fabric's byte producers and consumers and a single `uart_wb` instance, so no CPU polling is needed.

---
 rtl/uart_wb_sched.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_wb_sched.sv
// Wishbone master for one uart_wb instance: it programs the divider, polls status,
// drains RX bytes and round-robin arbitrates two TX byte requesters.
module uart_wb_sched #(
    parameter int unsigned          DW        = 16,
    parameter int unsigned          DIV_WIDTH = 8,
    parameter logic [DIV_WIDTH-1:0] DIV_INIT  = 8'd24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] div_val,
    input  logic                 div_upd,
    input  logic [7:0]           req0_data,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [7:0]           req1_data,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    output logic                 rx_ovf,
    output logic                 cfg_done,
    output logic [1:0]           wbm_addr,
    output logic [DW-1:0]        wbm_wdata,
    output logic                 wbm_we,
    output logic                 wbm_cyc,
    input  logic [DW-1:0]        wbm_rdata,
    input  logic                 wbm_ack
);

    localparam logic [1:0]  ADDR_DATA    = 2'd0;
    localparam logic [1:0]  ADDR_CTRL    = 2'd1;
    localparam int unsigned BIT_RX_EMPTY = DW - 1;
    localparam int unsigned BIT_RX_OVF   = DW - 2;
    localparam int unsigned BIT_TX_FULL  = DW - 4;

    typedef enum logic [2:0] {
        S_INIT,
        S_POLL,
        S_DECIDE,
        S_DIV,
        S_RXRD,
        S_TXWR
    } state_t;

    state_t                 state_q, state_d;
    logic                   cyc_q, cyc_d;
    logic                   we_q, we_d;
    logic [1:0]             addr_q, addr_d;
    logic [DW-1:0]          wdata_q, wdata_d;
    logic                   rdy0_q, rdy0_d;
    logic                   rdy1_q, rdy1_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   rx_ovf_q, rx_ovf_d;
    logic                   cfg_done_q, cfg_done_d;
    logic                   rx_empty_q, rx_empty_d;
    logic                   tx_full_q, tx_full_d;
    logic                   rr_q, rr_d;
    logic                   pend_q, pend_d;
    logic [DIV_WIDTH-1:0]   pdiv_q, pdiv_d;

    logic                   acked;
    logic                   any_req;
    logic                   gnt1;
    logic                   unused_rdata;

    assign acked   = cyc_q && wbm_ack;
    assign any_req = req0_valid || req1_valid;
    // Both pending: honour the round-robin pointer; otherwise take whoever is asking.
    assign gnt1    = (req0_valid && req1_valid) ? rr_q : req1_valid;

    assign unused_rdata = ^{wbm_rdata[DW-3], wbm_rdata[DW-5:8]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_INIT;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 2'd0;
            wdata_q    <= '0;
            rdy0_q     <= 1'b0;
            rdy1_q     <= 1'b0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            rx_ovf_q   <= 1'b0;
            cfg_done_q <= 1'b0;
            rx_empty_q <= 1'b1;
            tx_full_q  <= 1'b1;
            rr_q       <= 1'b0;
            pend_q     <= 1'b0;
            pdiv_q     <= '0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdy0_q     <= rdy0_d;
            rdy1_q     <= rdy1_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ovf_q   <= rx_ovf_d;
            cfg_done_q <= cfg_done_d;
            rx_empty_q <= rx_empty_d;
            tx_full_q  <= tx_full_d;
            rr_q       <= rr_d;
            pend_q     <= pend_d;
            pdiv_q     <= pdiv_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdy0_d     = 1'b0;
        rdy1_d     = 1'b0;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_ovf_d   = 1'b0;
        cfg_done_d = cfg_done_q;
        rx_empty_d = rx_empty_q;
        tx_full_d  = tx_full_q;
        rr_d       = rr_q;
        pend_d     = pend_q;
        pdiv_d     = pdiv_q;

        case (state_q)
            S_INIT: begin
                if (!cyc_q) begin
                    cyc_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = ADDR_CTRL;
                    wdata_d = DW'(DIV_INIT);
                end else if (wbm_ack) begin
                    cyc_d      = 1'b0;
                    cfg_done_d = 1'b1;
                    state_d    = S_POLL;
                end
            end
            S_POLL: begin
                if (!cyc_q) begin
                    cyc_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = ADDR_CTRL;
                    wdata_d = '0;
                end else if (wbm_ack) begin
                    cyc_d      = 1'b0;
                    rx_empty_d = wbm_rdata[BIT_RX_EMPTY];
                    tx_full_d  = wbm_rdata[BIT_TX_FULL];
                    rx_ovf_d   = wbm_rdata[BIT_RX_OVF];
                    state_d    = S_DECIDE;
                end
            end
            // Bus is idle this cycle; the chosen transaction launches at its end.
            S_DECIDE: begin
                if (pend_q) begin
                    cyc_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = ADDR_CTRL;
                    wdata_d = DW'(pdiv_q);
                    pend_d  = 1'b0;
                    state_d = S_DIV;
                end else if (!rx_empty_q) begin
                    cyc_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = ADDR_DATA;
                    wdata_d = '0;
                    state_d = S_RXRD;
                end else if (!tx_full_q && any_req) begin
                    cyc_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = ADDR_DATA;
                    wdata_d = gnt1 ? DW'(req1_data) : DW'(req0_data);
                    rdy0_d  = !gnt1;
                    rdy1_d  = gnt1;
                    rr_d    = !gnt1;
                    state_d = S_TXWR;
                end else begin
                    state_d = S_POLL;
                end
            end
            S_DIV, S_TXWR: begin
                if (acked) begin
                    cyc_d   = 1'b0;
                    state_d = S_POLL;
                end
            end
            S_RXRD: begin
                if (acked) begin
                    cyc_d   = 1'b0;
                    state_d = S_POLL;
                    if (!wbm_rdata[BIT_RX_EMPTY]) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = wbm_rdata[7:0];
                    end
                end
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = S_INIT;
            end
        endcase

        // Pending is cleared when the DIV write launches, so a strobe during DIV re-arms it.
        if (div_upd) begin
            pend_d = 1'b1;
            pdiv_d = div_val;
        end
    end

    assign wbm_cyc    = cyc_q;
    assign wbm_we     = we_q;
    assign wbm_addr   = addr_q;
    assign wbm_wdata  = wdata_q;
    assign req0_ready = rdy0_q;
    assign req1_ready = rdy1_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_ovf     = rx_ovf_q;
    assign cfg_done   = cfg_done_q;

endmodule
